// File: rtl/pipeline_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_issue_scoreboard
// Purpose  : Issue controller for the 5-stage pipeline. Keeps one busy bit per
//            architectural register for writes that are in flight, counts
//            issued-but-unretired instructions, and decides each cycle whether
//            the decode-stage instruction may advance to execute. Stalls on
//            RAW, WAW and in-flight-limit hazards.
// Ports    : clk, rst (async, active-high), clk_enable (global step enable)
//            i_dec_*      decode-stage instruction (sources s/t, destination)
//            i_wb_*       instruction retiring from writeback
//            i_flush      discard all in-flight tracking
//            o_issue      decode advances this cycle (combinational)
//            o_stall      decode holds a valid instruction that cannot issue
//            o_busy_mask  registered scoreboard, bit r = write to r pending
//            o_in_flight  issued-not-retired count
//            o_err        sticky underflow / clear-of-idle-register flag
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_issue_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_IN_FLIGHT  = 4,
  localparam int CNT_W         = $clog2(MAX_IN_FLIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_enable,
  input  logic                      i_dec_valid,
  input  logic                      i_dec_s_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_s_addr,
  input  logic                      i_dec_t_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_t_addr,
  input  logic                      i_dec_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_dec_wr_addr,
  input  logic                      i_wb_valid,
  input  logic                      i_wb_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_wr_addr,
  input  logic                      i_flush,
  output logic                      o_issue,
  output logic                      o_stall,
  output logic [NUM_REGS-1:0]       o_busy_mask,
  output logic [CNT_W-1:0]          o_in_flight,
  output logic                      o_err
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_IN_FLIGHT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  // Register 0 is hard-wired zero; addresses beyond NUM_REGS have no storage.
  // Neither is ever tracked, so they never create hazards.
  function automatic logic tracked(input logic [REG_ADDR_WIDTH-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic w_raw_s, w_raw_t, w_waw, w_full;
  logic w_set, w_clr;

  // Hazard detection looks only at registered state: a register freed by
  // writeback this cycle still reads as busy until the next edge.
  always_comb begin
    w_raw_s = i_dec_s_used && tracked(i_dec_s_addr) && busy_q[i_dec_s_addr];
    w_raw_t = i_dec_t_used && tracked(i_dec_t_addr) && busy_q[i_dec_t_addr];
    w_waw   = i_dec_wr_en  && tracked(i_dec_wr_addr) && busy_q[i_dec_wr_addr];
    w_full  = (cnt_q == c_max_cnt);
    o_issue = clk_enable && !rst && !i_flush && i_dec_valid &&
              !w_raw_s && !w_raw_t && !w_waw && !w_full;
    o_stall = i_dec_valid && !o_issue && !rst;
    w_set   = o_issue && i_dec_wr_en && tracked(i_dec_wr_addr);
    w_clr   = i_wb_valid && i_wb_wr_en && tracked(i_wb_wr_addr);
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (clk_enable) begin
      if (i_flush) begin
        // Flush wins over any retire presented in the same cycle; o_issue is
        // already forced low, and the error flag is left alone.
        busy_d = '0;
        cnt_d  = '0;
      end else begin
        if (w_clr) begin
          if (busy_q[i_wb_wr_addr]) begin
            busy_d[i_wb_wr_addr] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        // Applied after the clear so a same-register set/clear leaves it set.
        if (w_set) begin
          busy_d[i_dec_wr_addr] = 1'b1;
        end
        if (o_issue && !i_wb_valid) begin
          cnt_d = cnt_q + c_one;
        end else if (!o_issue && i_wb_valid) begin
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q - c_one;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign o_busy_mask = busy_q;
  assign o_in_flight = cnt_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_issue_scoreboard
// Purpose  : Self-checking bench for pipeline_issue_scoreboard. A table of
//            per-cycle stimulus records carries the expected combinational
//            issue/stall decision and the expected register state after the
//            edge; the post-edge expectation is queued when the stimulus is
//            driven and popped once the edge has happened.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_issue_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int AW       = 5;
  localparam int MAXF     = 4;
  localparam int CW       = $clog2(MAXF + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_enable;
  logic          i_dec_valid, i_dec_s_used, i_dec_t_used, i_dec_wr_en;
  logic [AW-1:0] i_dec_s_addr, i_dec_t_addr, i_dec_wr_addr;
  logic          i_wb_valid, i_wb_wr_en, i_flush;
  logic [AW-1:0] i_wb_wr_addr;
  logic          o_issue, o_stall, o_err;
  logic [NUM_REGS-1:0] o_busy_mask;
  logic [CW-1:0]       o_in_flight;

  pipeline_issue_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_ADDR_WIDTH(AW), .MAX_IN_FLIGHT(MAXF)
  ) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .i_dec_valid(i_dec_valid), .i_dec_s_used(i_dec_s_used), .i_dec_s_addr(i_dec_s_addr),
    .i_dec_t_used(i_dec_t_used), .i_dec_t_addr(i_dec_t_addr),
    .i_dec_wr_en(i_dec_wr_en), .i_dec_wr_addr(i_dec_wr_addr),
    .i_wb_valid(i_wb_valid), .i_wb_wr_en(i_wb_wr_en), .i_wb_wr_addr(i_wb_wr_addr),
    .i_flush(i_flush), .o_issue(o_issue), .o_stall(o_stall),
    .o_busy_mask(o_busy_mask), .o_in_flight(o_in_flight), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ce, dv, su; int sa; bit tu; int ta; bit we; int wa;
    bit wbv, wbwe; int wba; bit fl;
    bit ei, es; logic [31:0] eb; int ec; bit ee;
  } vec_t;

  typedef struct { logic [31:0] eb; int ec; bit ee; int id; } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(bit ce, bit dv, bit su, int sa, bit tu, int ta,
                              bit we, int wa, bit wbv, bit wbwe, int wba, bit fl,
                              bit ei, bit es, logic [31:0] eb, int ec, bit ee);
    vec_t v;
    v.ce = ce; v.dv = dv; v.su = su; v.sa = sa; v.tu = tu; v.ta = ta;
    v.we = we; v.wa = wa; v.wbv = wbv; v.wbwe = wbwe; v.wba = wba; v.fl = fl;
    v.ei = ei; v.es = es; v.eb = eb; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, id, act, exp);
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after
  // the following rising edge.
  task automatic step(input vec_t v, input int id);
    exp_t e;
    clk_enable    = v.ce;
    i_dec_valid   = v.dv;
    i_dec_s_used  = v.su;  i_dec_s_addr  = v.sa[AW-1:0];
    i_dec_t_used  = v.tu;  i_dec_t_addr  = v.ta[AW-1:0];
    i_dec_wr_en   = v.we;  i_dec_wr_addr = v.wa[AW-1:0];
    i_wb_valid    = v.wbv; i_wb_wr_en    = v.wbwe;
    i_wb_wr_addr  = v.wba[AW-1:0];
    i_flush       = v.fl;
    #3;
    chk("issue", id, 32'(o_issue), 32'(v.ei));
    chk("stall", id, 32'(o_stall), 32'(v.es));
    e.eb = v.eb; e.ec = v.ec; e.ee = v.ee; e.id = id;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("busy_mask", e.id, o_busy_mask, e.eb);
    chk("in_flight", e.id, 32'(o_in_flight), 32'(e.ec));
    chk("err", e.id, 32'(o_err), 32'(e.ee));
  endtask

  initial begin
    //          ce dv su sa tu ta we wa wbv wbwe wba fl | issue stall busy       cnt err
    // write r3, then RAW on s and t, WAW, writeback release
    tbl.push_back(mk(1,1,0,0, 0,0, 1,3,  0,0,0,  0, 1,0,32'h0000_0008,1,0));
    tbl.push_back(mk(1,1,1,3, 0,0, 1,8,  0,0,0,  0, 0,1,32'h0000_0008,1,0));
    tbl.push_back(mk(1,1,1,3, 0,0, 1,8,  1,1,3,  0, 0,1,32'h0000_0000,0,0));
    tbl.push_back(mk(1,1,1,3, 0,0, 1,8,  0,0,0,  0, 1,0,32'h0000_0100,1,0));
    tbl.push_back(mk(1,1,0,0, 1,8, 0,0,  0,0,0,  0, 0,1,32'h0000_0100,1,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,8,  0,0,0,  0, 0,1,32'h0000_0100,1,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,8,  0, 0,0,32'h0000_0000,0,0));
    // r0 reads/writes never tracked; count rises and falls
    tbl.push_back(mk(1,1,1,0, 1,0, 1,0,  0,0,0,  0, 1,0,32'h0000_0000,1,0));
    tbl.push_back(mk(1,1,1,0, 1,0, 1,0,  0,0,0,  0, 1,0,32'h0000_0000,2,0));
    tbl.push_back(mk(1,1,1,0, 1,0, 1,0,  1,0,0,  0, 1,0,32'h0000_0000,2,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,0,  0, 0,0,32'h0000_0000,1,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,0,0,  0, 0,0,32'h0000_0000,0,0));
    // fill to MAX_IN_FLIGHT, full stall, simultaneous issue+retire
    tbl.push_back(mk(1,1,0,0, 0,0, 1,1,  0,0,0,  0, 1,0,32'h0000_0002,1,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,2,  0,0,0,  0, 1,0,32'h0000_0006,2,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,3,  0,0,0,  0, 1,0,32'h0000_000E,3,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,4,  0,0,0,  0, 1,0,32'h0000_001E,4,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,9,  0,0,0,  0, 0,1,32'h0000_001E,4,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,1,  0, 0,0,32'h0000_001C,3,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,9,  1,1,2,  0, 1,0,32'h0000_0218,3,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,10, 0,0,0,  0, 1,0,32'h0000_0618,4,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,11, 0,0,0,  0, 0,1,32'h0000_0618,4,0));
    // flush blocks issue and clears tracking; flush with retire
    tbl.push_back(mk(1,1,0,0, 0,0, 1,11, 0,0,0,  1, 0,1,32'h0000_0000,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,5,  0,0,0,  0, 1,0,32'h0000_0020,1,0));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,6,  0,0,0,  0, 1,0,32'h0000_0060,2,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,5,  1, 0,0,32'h0000_0000,0,0));
    // retire at count 0 -> sticky err; clk_enable low freezes everything
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,7,  0, 0,0,32'h0000_0000,0,1));
    tbl.push_back(mk(1,1,0,0, 0,0, 1,12, 0,0,0,  0, 1,0,32'h0000_1000,1,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,1,0,0, 0,0, 1,13, 1,1,12, 0, 0,1,32'h0000_1000,1,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 0,0,  1,1,12, 0, 0,0,32'h0000_0000,0,1));

    // reset: decode valid held high, nothing may issue or stall
    rst = 1'b1;
    tbl[0].dv = tbl[0].dv; // keep table untouched; drive idle inputs below
    clk_enable = 1'b1; i_dec_valid = 1'b1; i_dec_s_used = 1'b0; i_dec_s_addr = '0;
    i_dec_t_used = 1'b0; i_dec_t_addr = '0; i_dec_wr_en = 1'b1; i_dec_wr_addr = 5'd3;
    i_wb_valid = 1'b0; i_wb_wr_en = 1'b0; i_wb_wr_addr = '0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_issue", -1, 32'(o_issue), 32'd0);
    chk("rst_stall", -1, 32'(o_stall), 32'd0);
    chk("rst_busy",  -1, o_busy_mask, 32'd0);
    chk("rst_cnt",   -1, 32'(o_in_flight), 32'd0);
    chk("rst_err",   -1, 32'(o_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // put some state in flight, then hit reset mid-cycle: clears without a clock edge
    step(mk(1,1,0,0, 0,0, 1,20, 0,0,0, 0, 1,0,32'h0010_0000,1,1), 100);
    i_dec_valid = 1'b1; i_dec_wr_en = 1'b1; i_dec_wr_addr = 5'd21;
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy",  101, o_busy_mask, 32'd0);
    chk("async_cnt",   101, 32'(o_in_flight), 32'd0);
    chk("async_err",   101, 32'(o_err), 32'd0);
    chk("async_issue", 101, 32'(o_issue), 32'd0);
    chk("async_stall", 101, 32'(o_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // clear of a non-busy register with count > 0: err set, mask and r14 kept
    step(mk(1,1,0,0, 0,0, 1,14, 0,0,0,  0, 1,0,32'h0000_4000,1,0), 102);
    step(mk(1,1,1,14,0,0, 0,0,  1,1,15, 0, 0,1,32'h0000_4000,0,1), 103);
    // r14 still busy: a t-read stalls, releases one cycle after its writeback
    step(mk(1,1,0,0, 1,14,0,0,  1,1,14, 0, 0,1,32'h0000_0000,0,1), 104);
    step(mk(1,1,0,0, 1,14,0,0,  0,0,0,  0, 1,0,32'h0000_0000,1,1), 105);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion by 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
